// File: rtl/mux2to1_pkg.sv
// Shared constants for the 2:1 ALU-operation selector and its optional output register.
// Select encodings are exported so the control unit drives SELECT by name.
package mux2to1_pkg;

  localparam int          DEFAULT_WIDTH     = 3;
  localparam logic [2:0]  DEFAULT_RESET_VAL = 3'b000;

  localparam logic SEL_IN1 = 1'b0;  // forward funct3
  localparam logic SEL_IN2 = 1'b1;  // forward forced constant (AUIPC/JAL)

  // Only an explicit 1 picks IN2; 0, X and Z all fall back to IN1.
  function automatic logic sel_is_in2(input logic sel);
    return (sel === SEL_IN2);
  endfunction

endpackage

// File: rtl/mux2to1_3bit_reg.sv
// Load-enabled pipeline register for the selector result, the captured select
// and a one-cycle pulse flagging that the captured select differs from the previous one.
module mux2to1_3bit_reg
  import mux2to1_pkg::*;
#(
  parameter int               WIDTH     = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(DEFAULT_RESET_VAL)
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  input  logic             sel,
  output logic [WIDTH-1:0] out_q,
  output logic             sel_q,
  output logic             sel_chg
);

  logic [WIDTH-1:0] out_q_reg;
  logic             sel_q_reg;
  logic             sel_chg_reg;

  always_ff @(posedge clk) begin
    if (srst) begin
      out_q_reg   <= RESET_VAL;
      sel_q_reg   <= SEL_IN1;
      sel_chg_reg <= 1'b0;
    end else if (en) begin
      out_q_reg   <= d;
      sel_q_reg   <= sel;
      sel_chg_reg <= sel ^ sel_q_reg;
    end else begin
      // Pulse lasts only for the cycle right after a load.
      sel_chg_reg <= 1'b0;
    end
  end

  assign out_q   = out_q_reg;
  assign sel_q   = sel_q_reg;
  assign sel_chg = sel_chg_reg;

endmodule

// File: rtl/mux_2to1_3bit.sv
// 2:1 selector for the ALU operation field: funct3 (IN1) or a forced constant (IN2).
// Define MUX2TO1_3BIT_REG_EN to build the registered OUT_Q/SEL_Q/SEL_CHG stage.
module mux_2to1_3bit
  import mux2to1_pkg::*;
#(
  parameter int               WIDTH     = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(DEFAULT_RESET_VAL)
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [WIDTH-1:0] IN1,
  input  logic [WIDTH-1:0] IN2,
  input  logic             SELECT,
  input  logic             EN,
  output logic [WIDTH-1:0] OUT,
  output logic [WIDTH-1:0] OUT_Q,
  output logic             SEL_Q,
  output logic             SEL_CHG
);

  logic sel_in2;

  assign sel_in2 = sel_is_in2(SELECT);

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    assign OUT[gi] = sel_in2 ? IN2[gi] : IN1[gi];
  end

`ifdef MUX2TO1_3BIT_REG_EN
  mux2to1_3bit_reg #(
    .WIDTH     (WIDTH),
    .RESET_VAL (RESET_VAL)
  ) u_reg (
    .clk     (CLK),
    .srst    (RESET),
    .en      (EN),
    .d       (OUT),
    .sel     (sel_in2),
    .out_q   (OUT_Q),
    .sel_q   (SEL_Q),
    .sel_chg (SEL_CHG)
  );
`else
  // Control-unit build: no state, the "registered" outputs simply mirror the selector.
  logic unused_ok;

  assign OUT_Q     = OUT;
  assign SEL_Q     = sel_in2;
  assign SEL_CHG   = 1'b0;
  assign unused_ok = &{1'b0, CLK, RESET, EN, RESET_VAL};
`endif

endmodule

// File: tb/tb_mux_2to1_3bit.sv
// Directed self-checking bench for mux_2to1_3bit; covers both the registered
// build (MUX2TO1_3BIT_REG_EN) and the combinational-only build.
module tb_mux_2to1_3bit;
  import mux2to1_pkg::*;

  localparam int W = 3;

  logic         CLK = 1'b0;
  logic         RESET;
  logic [W-1:0] IN1;
  logic [W-1:0] IN2;
  logic         SELECT;
  logic         EN;
  logic [W-1:0] OUT;
  logic [W-1:0] OUT_Q;
  logic         SEL_Q;
  logic         SEL_CHG;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 CLK = ~CLK;

  mux_2to1_3bit dut (
    .CLK     (CLK),
    .RESET   (RESET),
    .IN1     (IN1),
    .IN2     (IN2),
    .SELECT  (SELECT),
    .EN      (EN),
    .OUT     (OUT),
    .OUT_Q   (OUT_Q),
    .SEL_Q   (SEL_Q),
    .SEL_CHG (SEL_CHG)
  );

  task automatic test_passthrough();
    logic [W-1:0] exp;
    IN1 = 3'b101; IN2 = 3'b000; SELECT = SEL_IN1;
    #2;
    exp = 3'b101;
    tests_run++;
    if (OUT !== exp) begin
      tests_failed++;
      $display("FAIL passthrough_sel0: OUT=%b expected %b", OUT, exp);
    end else $display("[TB] passthrough_sel0 OUT=%b", OUT);
    SELECT = SEL_IN2;
    #2;
    exp = 3'b000;
    tests_run++;
    if (OUT !== exp) begin
      tests_failed++;
      $display("FAIL passthrough_sel1: OUT=%b expected %b", OUT, exp);
    end else $display("[TB] passthrough_sel1 OUT=%b", OUT);
    IN1 = 3'b110; IN2 = 3'b011; SELECT = SEL_IN2;
    #2;
    exp = 3'b011;
    tests_run++;
    if (OUT !== exp) begin
      tests_failed++;
      $display("FAIL passthrough_in2: OUT=%b expected %b", OUT, exp);
    end else $display("[TB] passthrough_in2 OUT=%b", OUT);
  endtask

  task automatic test_unknown_select();
    logic [W-1:0] exp;
    IN1 = 3'b011; IN2 = 3'b110; SELECT = 1'bx;
    #2;
    // A simulator without X may resolve the select to a real value; follow what it holds.
    exp = (SELECT === 1'b1) ? IN2 : IN1;
    tests_run++;
    if (OUT !== exp) begin
      tests_failed++;
      $display("FAIL unknown_select: OUT=%b expected %b", OUT, exp);
    end else $display("[TB] unknown_select OUT=%b", OUT);
  endtask

`ifdef MUX2TO1_3BIT_REG_EN
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_regs(input string name, input logic [W-1:0] eq,
                            input logic es, input logic ec);
    // no comparisons here: only reports state; comparisons are inline in callers
    $display("[TB] %s OUT_Q=%b SEL_Q=%b SEL_CHG=%b (want %b %b %b)",
             name, OUT_Q, SEL_Q, SEL_CHG, eq, es, ec);
  endtask

  task automatic test_reset();
    RESET = 1'b1; EN = 1'b0; IN1 = 3'b100; IN2 = 3'b001; SELECT = SEL_IN1;
    step();
    tests_run++;
    if (OUT_Q !== 3'b000 || SEL_Q !== 1'b0 || SEL_CHG !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_state: OUT_Q=%b SEL_Q=%b SEL_CHG=%b expected 000 0 0", OUT_Q, SEL_Q, SEL_CHG);
    end else check_regs("reset_state", 3'b000, 1'b0, 1'b0);
    tests_run++;
    if (OUT !== 3'b100) begin
      tests_failed++;
      $display("FAIL reset_out_follows: OUT=%b expected 100", OUT);
    end else $display("[TB] reset_out_follows OUT=%b", OUT);
  endtask

  task automatic test_reset_priority();
    RESET = 1'b0; EN = 1'b1; SELECT = SEL_IN1; IN1 = 3'b111;
    step();
    tests_run++;
    if (OUT_Q !== 3'b111) begin
      tests_failed++;
      $display("FAIL prio_preload: OUT_Q=%b expected 111", OUT_Q);
    end else check_regs("prio_preload", 3'b111, 1'b0, 1'b0);
    RESET = 1'b1; EN = 1'b1; SELECT = SEL_IN2; IN2 = 3'b101;
    step();
    tests_run++;
    if (OUT_Q !== 3'b000 || SEL_Q !== 1'b0 || SEL_CHG !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_priority: OUT_Q=%b SEL_Q=%b SEL_CHG=%b expected 000 0 0", OUT_Q, SEL_Q, SEL_CHG);
    end else check_regs("reset_priority", 3'b000, 1'b0, 1'b0);
    RESET = 1'b0;
  endtask

  task automatic test_load_hold();
    EN = 1'b1; SELECT = SEL_IN1; IN1 = 3'b010; IN2 = 3'b000;
    step();
    tests_run++;
    if (OUT_Q !== 3'b010 || SEL_CHG !== 1'b0) begin
      tests_failed++;
      $display("FAIL load: OUT_Q=%b SEL_CHG=%b expected 010 0", OUT_Q, SEL_CHG);
    end else check_regs("load", 3'b010, 1'b0, 1'b0);
    EN = 1'b0; IN1 = 3'b111;
    for (int i = 0; i < 3; i++) begin
      step();
      tests_run++;
      if (OUT_Q !== 3'b010 || SEL_Q !== 1'b0) begin
        tests_failed++;
        $display("FAIL hold_%0d: OUT_Q=%b SEL_Q=%b expected 010 0", i, OUT_Q, SEL_Q);
      end else check_regs("hold", 3'b010, 1'b0, 1'b0);
    end
  endtask

  task automatic test_sel_chg();
    RESET = 1'b1; EN = 1'b0;
    step();
    RESET = 1'b0; EN = 1'b1; SELECT = SEL_IN2; IN1 = 3'b101; IN2 = 3'b000;
    step();
    tests_run++;
    if (SEL_CHG !== 1'b1 || SEL_Q !== 1'b1 || OUT_Q !== 3'b000) begin
      tests_failed++;
      $display("FAIL chg_first_load: OUT_Q=%b SEL_Q=%b SEL_CHG=%b expected 000 1 1", OUT_Q, SEL_Q, SEL_CHG);
    end else check_regs("chg_first_load", 3'b000, 1'b1, 1'b1);
    step();
    tests_run++;
    if (SEL_CHG !== 1'b0 || SEL_Q !== 1'b1) begin
      tests_failed++;
      $display("FAIL chg_same_sel: SEL_Q=%b SEL_CHG=%b expected 1 0", SEL_Q, SEL_CHG);
    end else check_regs("chg_same_sel", 3'b000, 1'b1, 1'b0);
    SELECT = SEL_IN1;
    step();
    tests_run++;
    if (SEL_CHG !== 1'b1 || SEL_Q !== 1'b0 || OUT_Q !== 3'b101) begin
      tests_failed++;
      $display("FAIL chg_back_to_in1: OUT_Q=%b SEL_Q=%b SEL_CHG=%b expected 101 0 1", OUT_Q, SEL_Q, SEL_CHG);
    end else check_regs("chg_back_to_in1", 3'b101, 1'b0, 1'b1);
    EN = 1'b0; SELECT = SEL_IN2;
    step();
    tests_run++;
    if (SEL_CHG !== 1'b0 || SEL_Q !== 1'b0 || OUT_Q !== 3'b101) begin
      tests_failed++;
      $display("FAIL chg_idle_clear: OUT_Q=%b SEL_Q=%b SEL_CHG=%b expected 101 0 0", OUT_Q, SEL_Q, SEL_CHG);
    end else check_regs("chg_idle_clear", 3'b101, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    // Columns: SELECT, IN1, IN2, expected OUT_Q, expected SEL_CHG (SEL_Q starts at 0)
    logic [W-1:0] in1_v [6] = '{3'b001, 3'b010, 3'b011, 3'b100, 3'b101, 3'b110};
    logic [W-1:0] in2_v [6] = '{3'b111, 3'b110, 3'b101, 3'b100, 3'b011, 3'b010};
    logic         sel_v [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [W-1:0] q_v   [6] = '{3'b111, 3'b010, 3'b011, 3'b100, 3'b101, 3'b010};
    logic         chg_v [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    RESET = 1'b1;
    step();
    RESET = 1'b0; EN = 1'b1;
    for (int i = 0; i < 6; i++) begin
      SELECT = sel_v[i]; IN1 = in1_v[i]; IN2 = in2_v[i];
      step();
      tests_run++;
      if (OUT_Q !== q_v[i] || SEL_Q !== sel_v[i] || SEL_CHG !== chg_v[i]) begin
        tests_failed++;
        $display("FAIL b2b_%0d: OUT_Q=%b SEL_Q=%b SEL_CHG=%b expected %b %b %b",
                 i, OUT_Q, SEL_Q, SEL_CHG, q_v[i], sel_v[i], chg_v[i]);
      end else check_regs("b2b", q_v[i], sel_v[i], chg_v[i]);
    end
    EN = 1'b0;
  endtask
`else
  task automatic test_macro_off();
    logic [W-1:0] exp;
    logic         exp_sel;
    for (int i = 0; i < 20; i++) begin
      IN1    = W'($urandom_range(0, 7));
      IN2    = W'($urandom_range(0, 7));
      SELECT = 1'($urandom_range(0, 1));
      EN     = 1'($urandom_range(0, 1));
      RESET  = 1'($urandom_range(0, 1));
      #3;
      exp     = SELECT ? IN2 : IN1;
      exp_sel = SELECT;
      tests_run++;
      if (OUT_Q !== exp || OUT !== exp || SEL_Q !== exp_sel || SEL_CHG !== 1'b0) begin
        tests_failed++;
        $display("FAIL macro_off_%0d: OUT=%b OUT_Q=%b SEL_Q=%b SEL_CHG=%b expected %b %b %b 0",
                 i, OUT, OUT_Q, SEL_Q, SEL_CHG, exp, exp, exp_sel);
      end else $display("[TB] macro_off_%0d sel=%b OUT_Q=%b", i, SELECT, OUT_Q);
    end
    RESET = 1'b0; EN = 1'b0;
  endtask
`endif

  initial begin
    RESET = 1'b1; EN = 1'b0; SELECT = SEL_IN1; IN1 = '0; IN2 = '0;
    test_passthrough();
    test_unknown_select();
`ifdef MUX2TO1_3BIT_REG_EN
    @(negedge CLK);
    test_reset();
    test_reset_priority();
    test_load_hold();
    test_sel_chg();
    test_back_to_back();
`else
    test_macro_off();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/mux_2to1_3bit.md
# mux_2to1_3bit

Two-input, 3-bit-wide selector used in the CPU control unit to choose the ALU operation field. With SELECT low it forwards the instruction funct3 (IN1). With SELECT high it forwards a forced constant (IN2, tied to 3'b000 for AUIPC/JAL). It provides a combinational output plus an optional registered copy with load enable and select-change status, for pipeline-stage use.

## Interface
- WIDTH, default 3: data width of both inputs and both data outputs; 3 in the control unit.
- RESET_VAL, default 3'b000: value loaded into OUT_Q on reset.
- CLK  input  1  system clock; all state updates on the rising edge.
- RESET  input  1  synchronous, active-high reset.
- IN1  input  WIDTH  data selected when SELECT = 0 (funct3).
- IN2  input  WIDTH  data selected when SELECT = 1 (forced constant).
- SELECT  input  1  selector.
- EN  input  1  load enable for the registered stage.
- OUT  output  WIDTH  combinational selection result.
- OUT_Q  output  WIDTH  registered selection result.
- SEL_Q  output  1  SELECT value captured with the last load.
- SEL_CHG  output  1  one-cycle pulse: the last load captured a SELECT different from the previous SEL_Q.

## Operation
- OUT = IN2 when SELECT == 1, otherwise IN1. Any non-1 SELECT value (0, X or Z) selects IN1, so the decoder never emits X.
- The data path is purely combinational from IN1/IN2/SELECT to OUT. It has no dependence on CLK, RESET or EN.
- Registered stage, on each rising edge:
  - RESET = 1: OUT_Q, SEL_Q and SEL_CHG are cleared (OUT_Q takes RESET_VAL). This takes priority over EN.
  - EN = 1: OUT_Q takes OUT. SEL_Q takes SELECT. SEL_CHG = (SELECT != old SEL_Q).
  - EN = 0: OUT_Q and SEL_Q hold. SEL_CHG is cleared.
- Widths are equal on all data paths. There is no truncation or extension.

## Timing
- OUT: zero-cycle latency.
- OUT_Q/SEL_Q: one-cycle latency from an EN-qualified edge.
- SEL_CHG: valid the cycle after the load, for exactly one cycle.
- Reset values: OUT_Q = RESET_VAL (3'b000), SEL_Q = 0, SEL_CHG = 0. OUT keeps following its inputs during reset.
- Reset asserted mid-stream: the next edge clears state regardless of EN. The first load after reset compares against SEL_Q = 0.
- Back-to-back EN: every cycle loads and every select toggle pulses SEL_CHG.
- Inputs and SELECT changing in the same cycle: OUT_Q reflects the values present at the edge.

## Configuration
- MUX2TO1_3BIT_REG_EN defined: the registered stage is built as described.
- MUX2TO1_3BIT_REG_EN undefined:
  - OUT_Q is driven combinationally equal to OUT.
  - SEL_Q is driven combinationally equal to (SELECT == 1).
  - SEL_CHG is tied to 0.
  - No flops are inferred. CLK, RESET and EN are unused.
  - The control unit build uses this mode.

## Structure
- Shared package mux2to1_pkg holds:
  - the WIDTH default (3);
  - RESET_VAL (3'b000);
  - localparam SEL_IN1 = 1'b0 and SEL_IN2 = 1'b1, used by the control unit when driving SELECT.
- One natural sub-module, mux2to1_3bit_reg, holds the EN/RESET register for OUT_Q/SEL_Q/SEL_CHG. It is instantiated only under MUX2TO1_3BIT_REG_EN.
- The combinational selector stays in the top module.

## Test plan
- Pass-through: IN1=3'b101, IN2=3'b000, SELECT=0 -> OUT=3'b101. With SELECT=1 -> OUT=3'b000, with no clock edge required.
- Unknown select: SELECT=1'bx, IN1=3'b011, IN2=3'b110 -> OUT=3'b011, with no X on OUT.
- Reset priority: OUT_Q=3'b111, RESET=1 and EN=1 on the same edge -> OUT_Q=3'b000, SEL_Q=0, SEL_CHG=0 after the edge.
- Load and hold:
  - EN=1 with SELECT=0, IN1=3'b010 -> OUT_Q=3'b010 after one edge.
  - Then EN=0 and IN1=3'b111 for 3 cycles -> OUT_Q stays 3'b010.
- Select-change pulse: after reset, load with SELECT=1 -> SEL_CHG=1 for one cycle. A second load with SELECT=1 -> SEL_CHG=0. A load with SELECT=0 -> SEL_CHG=1.
- Macro off: build without MUX2TO1_3BIT_REG_EN -> OUT_Q tracks OUT in the same cycle under random IN1/IN2/SELECT, and SEL_CHG stays 0.
